wb_unit: RTL and testbench
==========================

# wb_unit

Write-back stage that drives the register file's write port (`reg_write`, `w_reg`, `w_data`). It merges two result sources: a single-cycle ALU path that cannot be back-pressured in normal operation, and a load-data path with a valid/ready handshake. Load data is sign- or zero-extended and buffered in a small FIFO, and ALU results have priority. A starvation counter forces a load write by holding the ALU path upstream.

## Interface

Parameters:
- `DEPTH`, 2: load FIFO entries (power of two, ≥2).
- `STARVE_LIMIT`, 4: cycles a non-empty FIFO head may wait before `stall_req` asserts.

Ports:
- `clk` in 1: clock, rising edge.
- `rst_n` in 1: asynchronous active-low reset.
- `alu_valid` in 1: ALU result present this cycle.
- `alu_rd` in 5: ALU destination register.
- `alu_data` in 32: ALU result.
- `stall_req` out 1: while high, upstream must hold `alu_valid`/`alu_rd`/`alu_data` stable; the ALU result is not accepted.
- `ld_valid` in 1: load result offered.
- `ld_ready` out 1: FIFO can accept a load.
- `ld_rd` in 5: load destination register.
- `ld_data` in 32: raw memory word.
- `ld_addr_lo` in 2: byte address bits [1:0].
- `ld_size` in 2: 00 byte, 01 half, 10 word, 11 treated as word.
- `ld_signed` in 1: 1 sign-extend, 0 zero-extend.
- `reg_write` out 1: register-file write enable, registered.
- `w_reg` out 5: write address, registered.
- `w_data` out 32: write data, registered.

## Operation

- **Load extension** is applied at push, so FIFO entries hold final data. Byte order is little-endian.
  - Byte: lane = `ld_addr_lo`.
  - Half: lane = `ld_addr_lo[1]`; `ld_addr_lo[0]` is ignored.
  - Word: `ld_addr_lo` is ignored.
- **Push:** occurs when `ld_valid && ld_ready`. `ld_ready = (count < DEPTH)`. It does not account for a same-cycle pop.
- **Selection each cycle**, with `alu_acc = alu_valid && !stall_req`:
  - If `alu_acc`: the ALU result is registered to the outputs.
  - Else if FIFO is non-empty: pop the head and register it to the outputs.
  - Else: `reg_write` = 0 next cycle.
- **Register r0:** a selected entry with rd = 0 is consumed (ALU accepted, or FIFO popped). `reg_write` = 0 for that cycle, and `w_reg`/`w_data` still update.
- **Idle outputs:** when nothing is selected, `w_reg`/`w_data` hold their previous values.
- **Starvation counter `age`** (width ≥ clog2(STARVE_LIMIT+1)):
  - Resets to 0 whenever the FIFO is empty or a pop occurs.
  - Otherwise increments, saturating at STARVE_LIMIT.
- **Stall:** `stall_req = (age == STARVE_LIMIT) && count != 0`, combinational from state.
  - When it is high, `alu_acc` = 0, so the head is popped that cycle and `age` clears.
- **Simultaneous push and pop:** count stays the same. Push into a full FIFO is impossible because `ld_ready` = 0.
- **Reset** (asynchronous, any time): FIFO is flushed (count = 0, pointers = 0) and `age` = 0. Pending loads are lost.

## Timing

- **Reset values:**
  - `reg_write` = 0, `w_reg` = 0, `w_data` = 0.
  - `stall_req` = 0, `ld_ready` = 1.
- **ALU latency:** accepted at edge N, so `reg_write` is high in the cycle after edge N (1 cycle).
- **Load latency:**
  - Pushed at edge N; earliest pop at edge N+1; `reg_write` high after edge N+1 (2 cycles minimum).
  - Only loads from an empty FIFO, with no ALU traffic, see this minimum.
- **`ld_ready` timing:** falls in the cycle after the push that fills the FIFO. It rises in the cycle after the pop.
- **Stall timing:** with continuous `alu_valid` and one FIFO entry pushed at edge N:
  - `age` reaches STARVE_LIMIT after edge N+STARVE_LIMIT.
  - `stall_req` is high for exactly one cycle.
  - The load is written to the outputs at the following edge.
- **FIFO order:** strictly FIFO among loads. Relative order of ALU and load writes is not preserved.

## Test plan

1. **Reset, then load extension.** Push a byte load: `ld_data`=0x12345680, addr_lo=0, signed, rd=3.
   - Required: 2 cycles later `reg_write`=1, `w_reg`=3, `w_data`=0xFFFFFF80.
   - Same load with `ld_signed`=0: `w_data`=0x00000080.
2. **Half and word extension.** Half load with addr_lo=2, `ld_data`=0x8001_0000, unsigned: `w_data`=0x00008001. Word load: `w_data` equals `ld_data`, whatever `ld_addr_lo` is.
3. **Priority and back-pressure.** ALU valid every cycle (rd=5, data=i); push three loads back-to-back.
   - `ld_ready` drops after the second push.
   - `stall_req` pulses one cycle after the 4-cycle starvation window.
   - Loads are written in push order.
   - No ALU result is lost or duplicated: the ALU data sequence at the outputs is contiguous.
4. **r0 suppression.** ALU rd=0, data=0xDEAD: `reg_write`=0 the next cycle. A load to rd=0 drains from the FIFO with `reg_write`=0 and count decremented.
5. **Simultaneous push/pop.** Count=1, no ALU traffic, push at the same edge as the pop: count stays 1, the output is the old head, and the new entry is written the next cycle.
6. **Reset mid-operation.** FIFO full and `stall_req`=1; assert `rst_n`=0 between edges.
   - Outputs are immediately 0, `ld_ready`=1, and `stall_req`=0.
   - After release, no stale load is ever written.

Source files
------------

// File: rtl/wb_unit.sv
// Write-back stage: merges a non-stallable ALU result with buffered, extended load data
// onto the register-file write port; a starvation counter briefly holds the ALU upstream.
module wb_unit #(
    parameter int DEPTH        = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        alu_valid,
    input  logic [4:0]  alu_rd,
    input  logic [31:0] alu_data,
    output logic        stall_req,
    input  logic        ld_valid,
    output logic        ld_ready,
    input  logic [4:0]  ld_rd,
    input  logic [31:0] ld_data,
    input  logic [1:0]  ld_addr_lo,
    input  logic [1:0]  ld_size,
    input  logic        ld_signed,
    output logic        reg_write,
    output logic [4:0]  w_reg,
    output logic [31:0] w_data
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam int AW = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
    } ld_entry_t;

    ld_entry_t       mem [DEPTH];
    logic [PW-1:0]   wr_ptr, rd_ptr;
    logic [CW-1:0]   count;
    logic [AW-1:0]   age;

    logic            alu_acc, push, pop, fifo_nonempty;
    logic [7:0]      byte_sel;
    logic [15:0]     half_sel;
    logic [31:0]     ld_ext;
    ld_entry_t       head;

    // Extension happens before the FIFO so entries already hold register-ready data.
    always_comb begin
        byte_sel = ld_data[{ld_addr_lo, 3'b000} +: 8];
        half_sel = ld_addr_lo[1] ? ld_data[31:16] : ld_data[15:0];
        case (ld_size)
            2'b00:   ld_ext = {{24{ld_signed & byte_sel[7]}}, byte_sel};
            2'b01:   ld_ext = {{16{ld_signed & half_sel[15]}}, half_sel};
            default: ld_ext = ld_data;
        endcase
    end

    assign fifo_nonempty = (count != '0);
    assign ld_ready      = (count < CW'(DEPTH));
    assign stall_req     = (age == AW'(STARVE_LIMIT)) && fifo_nonempty;
    assign alu_acc       = alu_valid && !stall_req;
    assign pop           = !alu_acc && fifo_nonempty;
    assign push          = ld_valid && ld_ready;
    assign head          = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= '{rd: ld_rd, data: ld_ext};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            age    <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (!fifo_nonempty || pop)
                age <= '0;
            else if (age != AW'(STARVE_LIMIT))
                age <= age + 1'b1;
        end
    end

    // Writes to r0 are consumed but never reach the register file.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            reg_write <= 1'b0;
            w_reg     <= '0;
            w_data    <= '0;
        end else if (alu_acc) begin
            reg_write <= (alu_rd != 5'd0);
            w_reg     <= alu_rd;
            w_data    <= alu_data;
        end else if (pop) begin
            reg_write <= (head.rd != 5'd0);
            w_reg     <= head.rd;
            w_data    <= head.data;
        end else begin
            reg_write <= 1'b0;
        end
    end
endmodule

// File: tb/tb_wb_unit.sv
// Bench for wb_unit: directed steps followed by random traffic, each cycle checked
// against a queue-based model of the write-back rules.
module tb_wb_unit;
    localparam int DEPTH = 2;
    localparam int LIM   = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        alu_valid = 1'b0;
    logic [4:0]  alu_rd = '0;
    logic [31:0] alu_data = '0;
    logic        stall_req;
    logic        ld_valid = 1'b0;
    logic        ld_ready;
    logic [4:0]  ld_rd = '0;
    logic [31:0] ld_data = '0;
    logic [1:0]  ld_addr_lo = '0;
    logic [1:0]  ld_size = '0;
    logic        ld_signed = 1'b0;
    logic        reg_write;
    logic [4:0]  w_reg;
    logic [31:0] w_data;

    wb_unit #(.DEPTH(DEPTH), .STARVE_LIMIT(LIM)) dut (
        .clk(clk), .rst_n(rst_n),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
        .stall_req(stall_req),
        .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_rd(ld_rd), .ld_data(ld_data),
        .ld_addr_lo(ld_addr_lo), .ld_size(ld_size), .ld_signed(ld_signed),
        .reg_write(reg_write), .w_reg(w_reg), .w_data(w_data)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
    } ent_t;

    ent_t        q[$];
    int          age = 0;
    logic        exp_we = 1'b0;
    logic [4:0]  exp_reg = '0;
    logic [31:0] exp_dat = '0;
    bit          last_pop = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    // Little-endian lane pick, then sign/zero extension by arithmetic.
    function automatic logic [31:0] ext(input logic [31:0] d, input logic [1:0] a,
                                        input logic [1:0] sz, input logic s);
        logic [31:0] v, m;
        int sh;
        if (sz[1]) return d;
        if (sz == 2'b00) begin sh = 8 * a; m = 32'h80; end
        else begin sh = 16 * a[1]; m = 32'h8000; end
        v = (d >> sh) & ((m << 1) - 1);
        if (s) v = (v ^ m) - m;
        return v;
    endfunction

    function automatic bit model_stall();
        return (age == LIM) && (q.size() != 0);
    endfunction

    // One clock: inputs already driven at the falling edge.
    task automatic cycle();
        bit   acc, push, nonempty;
        ent_t e, e_new;
        chk("stall_req", stall_req, model_stall());
        chk("ld_ready", ld_ready, q.size() < DEPTH);
        acc      = alu_valid && !model_stall();
        push     = ld_valid && (q.size() < DEPTH);
        nonempty = (q.size() != 0);
        e_new.rd   = ld_rd;
        e_new.data = ext(ld_data, ld_addr_lo, ld_size, ld_signed);
        last_pop = 1'b0;
        @(posedge clk);
        if (acc) begin
            exp_we = (alu_rd != 0); exp_reg = alu_rd; exp_dat = alu_data;
        end else if (nonempty) begin
            e = q.pop_front();
            last_pop = 1'b1;
            exp_we = (e.rd != 0); exp_reg = e.rd; exp_dat = e.data;
        end else begin
            exp_we = 1'b0;
        end
        if (push) q.push_back(e_new);
        if (!nonempty || last_pop) age = 0;
        else if (age < LIM) age++;
        @(negedge clk);
        chk("reg_write", reg_write, exp_we);
        chk("w_reg", w_reg, exp_reg);
        chk("w_data", w_data, exp_dat);
    endtask

    task automatic model_reset();
        q.delete();
        age = 0; exp_we = 1'b0; exp_reg = '0; exp_dat = '0;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_we"}, reg_write, 1'b0);
        chk({tag, "_reg"}, w_reg, 5'd0);
        chk({tag, "_data"}, w_data, 32'd0);
        chk({tag, "_stall"}, stall_req, 1'b0);
        chk({tag, "_ready"}, ld_ready, 1'b1);
    endtask

    // Push one load into an idle unit and let it drain (two cycles).
    task automatic load(input logic [4:0] rd, input logic [31:0] d, input logic [1:0] a,
                        input logic [1:0] sz, input logic s);
        ld_valid = 1'b1; ld_rd = rd; ld_data = d; ld_addr_lo = a; ld_size = sz; ld_signed = s;
        cycle();
        ld_valid = 1'b0;
        cycle();
    endtask

    initial begin
        int   i, nld, next_alu, stall_cnt, guard;
        bit   pushed, stalled;
        int   seen[$];

        #1 rst_n = 1'b0;
        #2 model_reset();
        check_reset_outputs("rst0");
        @(negedge clk) rst_n = 1'b1;

        // Byte / half / word extension.
        load(5'd3, 32'h12345680, 2'd0, 2'b00, 1'b1);
        chk("t1_we", reg_write, 1'b1);
        chk("t1_reg", w_reg, 5'd3);
        chk("t1_sbyte", w_data, 32'hFFFFFF80);
        load(5'd3, 32'h12345680, 2'd0, 2'b00, 1'b0);
        chk("t1_ubyte", w_data, 32'h00000080);
        load(5'd4, 32'h80010000, 2'd2, 2'b01, 1'b0);
        chk("t2_uhalf", w_data, 32'h00008001);
        load(5'd4, 32'h80010000, 2'd3, 2'b01, 1'b1);
        chk("t2_shalf", w_data, 32'hFFFF8001);
        load(5'd6, 32'hCAFEBABE, 2'd3, 2'b10, 1'b1);
        chk("t2_word", w_data, 32'hCAFEBABE);
        load(5'd6, 32'h8BADF00D, 2'd1, 2'b11, 1'b1);
        chk("t2_word11", w_data, 32'h8BADF00D);

        // Continuous ALU traffic with three loads behind it.
        alu_valid = 1'b1; alu_rd = 5'd5;
        i = 0; nld = 0; next_alu = 0; stall_cnt = 0;
        for (int c = 0; c < 30; c++) begin
            alu_data = i;
            if (nld < 3) begin
                ld_valid = 1'b1; ld_rd = 5'd7 + 5'(nld); ld_data = $urandom; ld_size = 2'b10;
            end else begin
                ld_valid = 1'b0;
            end
            pushed  = ld_valid && (q.size() < DEPTH);
            stalled = model_stall();
            if (stall_req) stall_cnt++;
            cycle();
            if (pushed) nld++;
            if (!stalled) i++;
            if (reg_write && w_reg == 5'd5) begin
                chk("t3_alu_seq", w_data, next_alu);
                next_alu++;
            end
            if (last_pop) seen.push_back(int'(w_reg));
        end
        chk("t3_stall_pulses", stall_cnt, 3);
        chk("t3_alu_count", next_alu, i);
        chk("t3_load_count", seen.size(), 3);
        for (int k = 0; k < seen.size() && k < 3; k++) chk("t3_load_order", seen[k], 7 + k);

        // r0 suppression on both paths.
        alu_rd = 5'd0; alu_data = 32'h0000DEAD;
        cycle();
        chk("t4_alu_r0_we", reg_write, 1'b0);
        chk("t4_alu_r0_data", w_data, 32'h0000DEAD);
        alu_valid = 1'b0;
        load(5'd0, 32'h11112222, 2'd0, 2'b10, 1'b0);
        chk("t4_ld_r0_we", reg_write, 1'b0);
        chk("t4_ld_r0_data", w_data, 32'h11112222);
        chk("t4_ld_r0_ready", ld_ready, 1'b1);
        cycle();

        // Push in the same cycle as a pop.
        ld_valid = 1'b1; ld_rd = 5'd10; ld_data = 32'hAAAA0001; ld_size = 2'b10;
        cycle();
        ld_rd = 5'd11; ld_data = 32'hBBBB0002;
        cycle();
        chk("t5_old_head_reg", w_reg, 5'd10);
        chk("t5_old_head_data", w_data, 32'hAAAA0001);
        chk("t5_count_one", ld_ready, 1'b1);
        ld_valid = 1'b0;
        cycle();
        chk("t5_new_reg", w_reg, 5'd11);
        chk("t5_new_we", reg_write, 1'b1);

        // Fill the FIFO under ALU pressure until a stall, then reset between edges.
        alu_valid = 1'b1; alu_rd = 5'd9; alu_data = 32'h5;
        guard = 0;
        while (!(model_stall() && q.size() == DEPTH) && guard < 20) begin
            ld_valid = 1'b1; ld_rd = 5'd12; ld_data = $urandom;
            cycle();
            guard++;
        end
        chk("t6_reach_stall", guard < 20, 1'b1);
        chk("t6_stall_high", stall_req, 1'b1);
        chk("t6_full", ld_ready, 1'b0);
        #2 rst_n = 1'b0;
        #1 model_reset();
        check_reset_outputs("t6_rst");
        alu_valid = 1'b0; ld_valid = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        for (int c = 0; c < 8; c++) cycle();

        // Random traffic; ALU inputs held while a stall is predicted.
        for (int c = 0; c < 400; c++) begin
            if (!model_stall()) begin
                alu_valid = ($urandom_range(0, 1) == 1);
                alu_rd    = 5'($urandom_range(0, 31));
                alu_data  = $urandom;
            end
            ld_valid   = ($urandom_range(0, 2) != 0);
            ld_rd      = 5'($urandom_range(0, 31));
            ld_data    = $urandom;
            ld_addr_lo = 2'($urandom_range(0, 3));
            ld_size    = 2'($urandom_range(0, 3));
            ld_signed  = 1'($urandom_range(0, 1));
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
